// File: rtl/led_status_color_pkg.sv
// Shared colour definitions and WS2812 wire-order packing for the status LED.
package led_status_pkg;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;

  // Channel triple indexed by CH_R/CH_G/CH_B.
  typedef logic [2:0][7:0] rgb_t;

  localparam rgb_t COL_OFF   = '0;
  localparam rgb_t COL_RED   = {8'h00, 8'h00, 8'hFF};
  localparam rgb_t COL_GREEN = {8'h00, 8'hFF, 8'h00};
  localparam rgb_t COL_BLUE  = {8'hFF, 8'h00, 8'h00};

  // G, R, B in that order, each channel MSB-first from bit 0 upwards.
  function automatic logic [23:0] pack_wire(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [23:0] w;
    w = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w[i]      = g[7-i];
      w[8 + i]  = r[7-i];
      w[16 + i] = b[7-i];
    end
    return w;
  endfunction

endpackage

// File: rtl/led_status_color_tick_div.sv
// Period counter producing a registered one-cycle tick every PERIOD clocks.
module led_tick_div #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(PERIOD - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_status_color.sv
// Status-to-colour merger with linear fade and brightness shift, feeding the
// WS2812 driver a registered wire-order word.
module led_status_color
  import led_status_pkg::*;
#(
  parameter int unsigned CLK_FRE      = 32_000_000,
  parameter int unsigned STRETCH_MS   = 50,
  parameter int unsigned BLINK_MS     = 250,
  parameter int unsigned FADE_US      = 1000,
  parameter int unsigned BRIGHT_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_act,
  input  logic        fdd_act,
  input  logic        osd_open,
  input  logic        error,
  output logic [23:0] color
);

  localparam int unsigned MS_CYC   = CLK_FRE / 1000;
  localparam int unsigned FADE_CYC = CLK_FRE / 1_000_000 * FADE_US;
  localparam int unsigned SW       = $clog2(STRETCH_MS + 1);
  localparam int unsigned BW       = $clog2(BLINK_MS + 1);

  logic          ms_tick;
  logic          fade_tick;
  logic [SW-1:0] stretch;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          act_on;
  logic          upd;
  rgb_t          tgt;
  rgb_t          cur;
  rgb_t          cur_nxt;

  led_tick_div #(.PERIOD(MS_CYC)) u_ms_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (ms_tick)
  );

  led_tick_div #(.PERIOD(FADE_CYC)) u_fade_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (fade_tick)
  );

  // A new pulse reloads the full stretch even on an ms_tick cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stretch <= '0;
    end else if (sd_act || fdd_act) begin
      stretch <= SW'(STRETCH_MS);
    end else if (ms_tick && (stretch != '0)) begin
      stretch <= stretch - SW'(1);
    end
  end

  assign act_on = (stretch != '0);

  always_ff @(posedge clk) begin
    if (!reset_n || !error) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    tgt = COL_OFF;
    if (error) begin
      tgt = blink_ph ? COL_OFF : COL_RED;
    end else if (osd_open) begin
      tgt = COL_BLUE;
    end else if (act_on) begin
      tgt = COL_GREEN;
    end
  end

  always_comb begin
    cur_nxt = cur;
    for (int unsigned c = 0; c < 3; c++) begin
      if (cur[c] < tgt[c]) begin
        cur_nxt[c] = cur[c] + 8'd1;
      end else if (cur[c] > tgt[c]) begin
        cur_nxt[c] = cur[c] - 8'd1;
      end
    end
  end

  // The output word follows the fade step by one cycle so it is only ever
  // built from a settled channel value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur   <= '0;
      upd   <= 1'b0;
      color <= '0;
    end else begin
      upd <= fade_tick;
      if (fade_tick) begin
        cur <= cur_nxt;
      end
      if (upd) begin
        color <= pack_wire(cur[CH_R] >> BRIGHT_SHIFT,
                           cur[CH_G] >> BRIGHT_SHIFT,
                           cur[CH_B] >> BRIGHT_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_led_status_color.sv
// Self-checking bench for led_status_color: steady-state vector table plus
// hand-written sequences for stretch, retrigger, blink and mid-fade reset.
module tb_led_status_color;
  import led_status_pkg::*;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        sd_act   = 1'b0;
  logic        fdd_act  = 1'b0;
  logic        osd_open = 1'b0;
  logic        error    = 1'b0;
  logic [23:0] color;
  logic [23:0] color_b;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned tcyc   = 0;
  int unsigned t0     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  led_status_color #(
    .CLK_FRE(1_000_000), .STRETCH_MS(5), .BLINK_MS(2), .FADE_US(10), .BRIGHT_SHIFT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sd_act(sd_act), .fdd_act(fdd_act),
    .osd_open(osd_open), .error(error), .color(color)
  );

  led_status_color #(
    .CLK_FRE(1_000_000), .STRETCH_MS(5), .BLINK_MS(2), .FADE_US(10), .BRIGHT_SHIFT(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .sd_act(sd_act), .fdd_act(fdd_act),
    .osd_open(osd_open), .error(error), .color(color_b)
  );

  typedef struct {
    string       name;
    logic        err;
    logic        osd;
    logic        pulse;
    int unsigned cycles;
    logic [23:0] exp;
    logic [23:0] exp_b;
  } vec_t;

  typedef struct {
    string       name;
    logic [23:0] exp;
    logic [23:0] exp_b;
  } sb_t;

  vec_t vecs[5];
  sb_t  sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    n_chk++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cyc_to(input int unsigned t);
    while (tcyc - t0 < t) @(negedge clk);
  endtask

  task automatic do_reset(input logic err, input logic osd);
    @(negedge clk);
    reset_n  = 1'b0;
    error    = err;
    osd_open = osd;
    sd_act   = 1'b0;
    fdd_act  = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    t0      = tcyc;
  endtask

  task automatic wait_change(input string name, output logic [23:0] val);
    logic [23:0] prev;
    logic        seen;
    prev = color;
    seen = 1'b0;
    for (int unsigned i = 0; i < 100 && !seen; i++) begin
      cyc(1);
      if (color !== prev) seen = 1'b1;
    end
    val = color;
    if (!seen) begin
      n_chk++;
      $display("FAIL %s: no colour change within 100 cycles, still %h", name, color);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] v;
    logic        found;
    sb_t         e;

    vecs[0] = '{"idle",         1'b0, 1'b0, 1'b0, 20000, 24'h000000, 24'h000000};
    vecs[1] = '{"osd_blue",     1'b0, 1'b1, 1'b0,  2600, 24'hFF0000, 24'hFC0000};
    vecs[2] = '{"osd_over_act", 1'b0, 1'b1, 1'b1,  2600, 24'hFF0000, 24'hFC0000};
    vecs[3] = '{"act_green",    1'b0, 1'b0, 1'b1,  2600, 24'h0000FF, 24'h0000FC};
    vecs[4] = '{"act_expired",  1'b0, 1'b0, 1'b1,  8000, 24'h000000, 24'h000000};

    reset_n = 1'b0;
    cyc(2);
    check("reset_color", color, 24'h000000);

    for (int unsigned k = 0; k < 5; k++) begin
      do_reset(vecs[k].err, vecs[k].osd);
      fdd_act = vecs[k].pulse;
      sb_q.push_back('{vecs[k].name, vecs[k].exp, vecs[k].exp_b});
      cyc(1);
      fdd_act = 1'b0;
      cyc_to(vecs[k].cycles);
      e = sb_q.pop_front();
      check(e.name, color, e.exp);
      check({e.name, "_shift2"}, color_b, e.exp_b);
    end

    // Single pulse: first fade steps, hold, then decay after the stretch.
    do_reset(1'b0, 1'b0);
    fdd_act = 1'b1;
    cyc(1);
    fdd_act = 1'b0;
    wait_change("g_step1", v);
    check("g_step1", v, 24'h000080);
    wait_change("g_step2", v);
    check("g_step2", v, 24'h000040);
    wait_change("g_step3", v);
    check("g_step3", v, 24'h0000C0);
    cyc_to(3900);
    check("g_hold", color, 24'h0000FF);
    cyc_to(6000);
    check_rng("g_decay", int'(rev8(color[7:0])), 100, 200);
    check("g_decay_rb", color & 24'hFFFF00, 24'h000000);
    cyc_to(8000);
    check("g_off", color, 24'h000000);

    // Retrigger: second pulse 3 ms later extends the green hold.
    do_reset(1'b0, 1'b0);
    fdd_act = 1'b1;
    cyc(1);
    fdd_act = 1'b0;
    cyc_to(3000);
    sd_act = 1'b1;
    cyc(1);
    sd_act = 1'b0;
    cyc_to(6900);
    check("retrig_hold", color, 24'h0000FF);
    cyc_to(7950);
    check("retrig_hold_late", color, 24'h0000FF);
    cyc_to(10700);
    check("retrig_off", color, 24'h000000);

    // Error with OSD: red blinks with a 2 ms half-period, blue never rises.
    do_reset(1'b1, 1'b1);
    cyc_to(1950);
    check_rng("err_rise", int'(rev8(color[15:8])), 185, 200);
    check("err_rise_gb", color & 24'hFF00FF, 24'h000000);
    cyc_to(2500);
    check_rng("err_fall", int'(rev8(color[15:8])), 140, 160);
    check("err_fall_gb", color & 24'hFF00FF, 24'h000000);
    cyc_to(3950);
    check_rng("err_low", int'(rev8(color[15:8])), 0, 10);
    check("err_low_gb_b", color_b & 24'hFF00FF, 24'h000000);
    cyc_to(4500);
    check_rng("err_rise2", int'(rev8(color[15:8])), 40, 60);
    check("err_rise2_gb", color & 24'hFF00FF, 24'h000000);
    error    = 1'b0;
    osd_open = 1'b0;

    // Reset mid-fade clears instantly and the fade restarts from zero.
    do_reset(1'b0, 1'b0);
    fdd_act = 1'b1;
    cyc(1);
    fdd_act = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < 3000 && !found; i++) begin
      cyc(1);
      if (rev8(color[7:0]) == 8'd128) found = 1'b1;
    end
    check("mid_reach_128", {31'd0, found}, 32'd1);
    reset_n = 1'b0;
    cyc(1);
    check("mid_reset", color, 24'h000000);
    check("mid_reset_b", color_b, 24'h000000);
    reset_n = 1'b1;
    t0      = tcyc;
    fdd_act = 1'b1;
    cyc(1);
    fdd_act = 1'b0;
    wait_change("mid_restart", v);
    check("mid_restart", v, 24'h000080);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
